// File: rtl/encoder_scan_n_if.sv
// Request-scan encoder bus: control/request inputs and indexed output.
// Carries the valid/ready handshake plus busy/done/zero status.
interface encoder_scan_n_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  logic         En;
  logic         load;
  logic [N-1:0] Din;
  logic         ready;
  logic         valid;
  logic [W-1:0] E0;
  logic         busy;
  logic         done;
  logic         zero;

  modport master (
    output En, load, Din, ready,
    input  valid, E0, busy, done, zero
  );

  modport slave (
    input  En, load, Din, ready,
    output valid, E0, busy, done, zero
  );
endinterface

// File: rtl/encoder_scan_n.sv
// Sequential priority encoder: captures a request vector and emits
// the index of each set bit, one per accepted valid/ready beat.
module encoder_scan_n #(
  parameter int N         = 8,
  parameter bit PRIO_HIGH = 1'b1
) (
  input logic             clk,
  input logic             rst,
  encoder_scan_n_if.slave bus
);
  localparam int W = $clog2(N);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic [W-1:0] hold_q, hold_d;
  logic         done_q, done_d;
  logic         zero_q, zero_d;

  logic [W-1:0] enc;
  logic [N-1:0] clr;
  logic [N-1:0] rem;
  logic         busy;
  logic         valid;
  logic         fire;

  always_comb begin
    enc = '0;
    if (PRIO_HIGH) begin
      for (int i = 0; i < N; i++)
        if (pend_q[i]) enc = W'(i);
    end else begin
      for (int i = N - 1; i >= 0; i--)
        if (pend_q[i]) enc = W'(i);
    end
  end

  // E0 keeps the last encoded index once pend drains
  assign hold_d = (|pend_q) ? enc : hold_q;

  assign busy  = (state_q == SCAN);
  assign valid = busy && bus.En;
  assign fire  = valid && bus.ready;
  assign clr   = {{(N-1){1'b0}}, 1'b1} << enc;
  assign rem   = pend_q & ~clr;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    zero_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.En && bus.load) begin
          pend_d = bus.Din;
          if (|bus.Din) begin
            state_d = SCAN;
          end else begin
            done_d = 1'b1;
            zero_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (fire) begin
          pend_d = rem;
          if (rem == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.valid = valid;
  assign bus.E0    = hold_d;
  assign bus.busy  = busy;
  assign bus.done  = done_q;
  assign bus.zero  = zero_q;
endmodule

// File: tb/tb_encoder_scan_n.sv
// Bench for encoder_scan_n: three instances (N=8 high/low, N=16)
// share stimulus; a queue model tracks the pending indices of each.
module tb_encoder_scan_n;
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load;
  logic        ready;
  logic [15:0] din;

  always #5 clk = ~clk;

  encoder_scan_n_if #(.N(8))  b8h ();
  encoder_scan_n_if #(.N(8))  b8l ();
  encoder_scan_n_if #(.N(16)) b16 ();

  assign b8h.En    = en;
  assign b8h.load  = load;
  assign b8h.Din   = din[7:0];
  assign b8h.ready = ready;
  assign b8l.En    = en;
  assign b8l.load  = load;
  assign b8l.Din   = din[7:0];
  assign b8l.ready = ready;
  assign b16.En    = en;
  assign b16.load  = load;
  assign b16.Din   = din;
  assign b16.ready = ready;

  encoder_scan_n #(.N(8), .PRIO_HIGH(1'b1)) u8h (
    .clk(clk), .rst(rst), .bus(b8h.slave)
  );
  encoder_scan_n #(.N(8), .PRIO_HIGH(1'b0)) u8l (
    .clk(clk), .rst(rst), .bus(b8l.slave)
  );
  encoder_scan_n #(.N(16), .PRIO_HIGH(1'b1)) u16 (
    .clk(clk), .rst(rst), .bus(b16.slave)
  );

  typedef struct {
    logic [15:0] din;
    int          nb8;
    int          nb16;
  } vec_t;

  int   n_chk = 0;
  int   n_fail = 0;
  int   q[3][$];
  int   beats[3];
  logic exp_done[3];
  logic exp_zero[3];
  vec_t tbl[$];

  function automatic int nw(int d);
    return (d == 2) ? 16 : 8;
  endfunction

  function automatic bit ph(int d);
    return d != 1;
  endfunction

  task automatic chk(string nm, int d, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d, expected %0d",
               nm, d, act, exp);
    end
  endtask

  task automatic mon(int d, logic v, int e0, logic b,
                     logic dn, logic z);
    logic [15:0] dv;
    dv = (nw(d) == 16) ? din : {8'h00, din[7:0]};
    if (rst) begin
      q[d].delete();
      exp_done[d] = 1'b0;
      exp_zero[d] = 1'b0;
      return;
    end
    chk("done", d, int'(dn), int'(exp_done[d]));
    chk("zero", d, int'(z), int'(exp_zero[d]));
    chk("busy", d, int'(b), int'(q[d].size() != 0));
    chk("valid", d, int'(v), int'((q[d].size() != 0) && en));
    exp_done[d] = 1'b0;
    exp_zero[d] = 1'b0;
    if (q[d].size() != 0) begin
      if (en) begin
        chk("E0", d, e0, q[d][0]);
        if (ready) begin
          void'(q[d].pop_front());
          beats[d]++;
          if (q[d].size() == 0) exp_done[d] = 1'b1;
        end
      end
    end else if (en && load) begin
      if (dv == 16'h0) begin
        exp_done[d] = 1'b1;
        exp_zero[d] = 1'b1;
      end else if (ph(d)) begin
        for (int i = nw(d) - 1; i >= 0; i--)
          if (dv[i]) q[d].push_back(i);
      end else begin
        for (int i = 0; i < nw(d); i++)
          if (dv[i]) q[d].push_back(i);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, b8h.valid, int'(b8h.E0), b8h.busy, b8h.done, b8h.zero);
    mon(1, b8l.valid, int'(b8l.E0), b8l.busy, b8l.done, b8l.zero);
    mon(2, b16.valid, int'(b16.E0), b16.busy, b16.done, b16.zero);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_chk(string nm);
    chk({nm, " valid"}, 0, int'(b8h.valid), 0);
    chk({nm, " valid"}, 1, int'(b8l.valid), 0);
    chk({nm, " valid"}, 2, int'(b16.valid), 0);
    chk({nm, " busy"}, 0, int'(b8h.busy), 0);
    chk({nm, " busy"}, 1, int'(b8l.busy), 0);
    chk({nm, " busy"}, 2, int'(b16.busy), 0);
    chk({nm, " E0"}, 0, int'(b8h.E0), 0);
    chk({nm, " E0"}, 1, int'(b8l.E0), 0);
    chk({nm, " E0"}, 2, int'(b16.E0), 0);
    chk({nm, " done"}, 0, int'(b8h.done), 0);
    chk({nm, " done"}, 2, int'(b16.done), 0);
    chk({nm, " zero"}, 1, int'(b8l.zero), 0);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (q[0].size() == 0 && q[1].size() == 0
          && q[2].size() == 0) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    chk("scan timeout", 0, int'(ok), 1);
    repeat (2) cyc();
  endtask

  task automatic beats_chk(int b0[3], int nb8, int nb16);
    chk("beats", 0, beats[0] - b0[0], nb8);
    chk("beats", 1, beats[1] - b0[1], nb8);
    chk("beats", 2, beats[2] - b0[2], nb16);
  endtask

  task automatic run(vec_t v);
    int b0[3];
    for (int d = 0; d < 3; d++) b0[d] = beats[d];
    en    = 1'b1;
    ready = 1'b1;
    load  = 1'b1;
    din   = v.din;
    cyc();
    load  = 1'b0;
    din   = 16'($urandom);
    wait_idle();
    beats_chk(b0, v.nb8, v.nb16);
  endtask

  initial begin
    int b0[3];
    for (int d = 0; d < 3; d++) begin
      beats[d]    = 0;
      exp_done[d] = 1'b0;
      exp_zero[d] = 1'b0;
    end
    rst   = 1'b1;
    en    = 1'b0;
    load  = 1'b0;
    ready = 1'b0;
    din   = 16'h0;
    repeat (2) cyc();
    rst_chk("reset");
    rst = 1'b0;
    cyc();

    tbl.push_back('{16'h00A5, 4, 4});
    tbl.push_back('{16'h0000, 0, 0});
    tbl.push_back('{16'h0081, 2, 2});
    tbl.push_back('{16'h00FF, 8, 8});
    for (int i = 0; i < 16; i++)
      tbl.push_back('{16'(1 << i), (i < 8) ? 1 : 0, 1});
    tbl.push_back('{16'hFFFF, 8, 16});
    tbl.push_back('{16'h5A00, 0, 4});
    foreach (tbl[k]) run(tbl[k]);

    // backpressure then enable gap on 8'b1000_0010
    for (int d = 0; d < 3; d++) b0[d] = beats[d];
    en    = 1'b1;
    ready = 1'b0;
    load  = 1'b1;
    din   = 16'h0082;
    cyc();
    load  = 1'b0;
    repeat (3) cyc();
    ready = 1'b1;
    en    = 1'b0;
    repeat (2) cyc();
    en    = 1'b1;
    wait_idle();
    beats_chk(b0, 2, 2);

    // load while busy is ignored
    for (int d = 0; d < 3; d++) b0[d] = beats[d];
    load = 1'b1;
    din  = 16'h0030;
    cyc();
    din  = 16'hFFFF;
    cyc();
    load = 1'b0;
    wait_idle();
    beats_chk(b0, 2, 2);

    // reset after the first beat
    load = 1'b1;
    din  = 16'h0030;
    cyc();
    din  = 16'hFFFF;
    cyc();
    load = 1'b0;
    rst  = 1'b1;
    cyc();
    rst  = 1'b0;
    rst_chk("midreset");
    repeat (3) cyc();

    run('{16'h00A5, 4, 4});

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
